perceptron_predictor_gen2: RTL and testbench

//  Parametrised perceptron branch predictor: PC-indexed table of signed weight vectors, global outcome history.

---
 rtl/perceptron_pkg.sv | 24 ++
 rtl/perceptron_inflight_fifo.sv | 57 +++++
 rtl/perceptron_predictor_gen2.sv | 162 ++++++++++++++++
 tb/tb_perceptron_predictor_gen2.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/perceptron_pkg.sv
// Shared types and helpers for the perceptron branch predictor.
package perceptron_pkg;

    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    localparam int unsigned THRESHOLD_DEFAULT = 29;

    // Step a weight by +/-1, clamped to the symmetric range [-max_mag, +max_mag].
    function automatic int sat_add(input int w, input logic up, input int max_mag);
        int r;
        r = up ? w + 1 : w - 1;
        if (r > max_mag) begin
            r = max_mag;
        end
        if (r < -max_mag) begin
            r = -max_mag;
        end
        return r;
    endfunction

endpackage

// File: rtl/perceptron_inflight_fifo.sv
// Entry FIFO for in-flight predictions; a separate count distinguishes full from empty.
module perceptron_inflight_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

// File: rtl/perceptron_predictor_gen2.sv
// Perceptron branch predictor with in-order training from an in-flight FIFO.
// Optional PERCEPTRON_GHASH_EN: XOR global history into the row index.
module perceptron_predictor_gen2
    import perceptron_pkg::*;
#(
    parameter int unsigned WEIGHT_BITS = 8,
    parameter int unsigned HIST_LEN    = 8,
    parameter int unsigned IDX_BITS    = 4,
    parameter int unsigned THRESHOLD   = THRESHOLD_DEFAULT,
    parameter int unsigned FIFO_DEPTH  = 8,
    localparam int unsigned Y_BITS     = WEIGHT_BITS + $clog2(HIST_LEN + 1) + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic [15:0]              pred_pc,
    output logic                     pred_ready,
    output logic                     pred_taken,
    output logic signed [Y_BITS-1:0] pred_y,
    input  logic                     res_valid,
    input  logic                     res_taken,
    output logic                     res_mispred,
    output logic                     res_err
);

    localparam int unsigned ROWS  = 2 ** IDX_BITS;
    localparam int unsigned NW    = HIST_LEN + 1;
    localparam int          WMAX  = 2 ** (WEIGHT_BITS - 1) - 1;
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

    // Entry widths follow the module parameters, so the type lives here.
    typedef struct packed {
        logic [IDX_BITS-1:0]      idx;
        logic signed [Y_BITS-1:0] y;
        logic [HIST_LEN-1:0]      hist;
        logic [HIST_LEN-1:0]      hist_valid;
    } entry_t;

    state_e                        state_q, state_d;
    logic [IDX_BITS-1:0]           row_q, row_d;
    logic [HIST_LEN-1:0]           hist_q, hist_valid_q;
    logic signed [WEIGHT_BITS-1:0] weights_q [ROWS][NW];
    logic                          res_mispred_q, res_err_q;

    logic [IDX_BITS-1:0]           pred_idx;
    logic signed [Y_BITS-1:0]      y_chain [NW];
    logic                          push, pop, train, mispred, within_thr;
    logic                          fifo_full, fifo_empty;
    logic [CNT_W-1:0]              fifo_count;
    entry_t                        push_e, pop_e;
    logic [$bits(entry_t)-1:0]     fifo_rdata;
    logic [Y_BITS-1:0]             y_abs;
    logic                          unused_pc;

    assign unused_pc = ^pred_pc[15:IDX_BITS];

`ifdef PERCEPTRON_GHASH_EN
    logic [IDX_BITS+HIST_LEN-1:0] hist_ext;
    logic                         unused_hist_ext;
    assign hist_ext        = {{IDX_BITS{1'b0}}, hist_q};
    assign unused_hist_ext = ^hist_ext[IDX_BITS+HIST_LEN-1:IDX_BITS];
    assign pred_idx        = pred_pc[IDX_BITS-1:0] ^ hist_ext[IDX_BITS-1:0];
`else
    assign pred_idx = pred_pc[IDX_BITS-1:0];
`endif

    // Dot product: bias plus signed history terms, only over valid history bits.
    assign y_chain[0] = {{(Y_BITS-WEIGHT_BITS){weights_q[pred_idx][0][WEIGHT_BITS-1]}},
                         weights_q[pred_idx][0]};
    for (genvar i = 0; i < HIST_LEN; i++) begin : g_dot
        logic signed [Y_BITS-1:0] w_ext, term;
        assign w_ext = {{(Y_BITS-WEIGHT_BITS){weights_q[pred_idx][i+1][WEIGHT_BITS-1]}},
                        weights_q[pred_idx][i+1]};
        assign term  = !hist_valid_q[i] ? '0 : (hist_q[i] ? w_ext : -w_ext);
        assign y_chain[i+1] = y_chain[i] + term;
    end

    assign pred_y      = y_chain[HIST_LEN];
    assign pred_taken  = !pred_y[Y_BITS-1] && (pred_y != '0);
    assign pred_ready  = (state_q == StRun) && !fifo_full;
    assign push        = pred_valid && pred_ready;
    assign pop         = res_valid && !fifo_empty && (state_q == StRun);

    assign push_e      = '{idx: pred_idx, y: pred_y, hist: hist_q, hist_valid: hist_valid_q};
    assign pop_e       = entry_t'(fifo_rdata);
    assign mispred     = (!pop_e.y[Y_BITS-1] && (pop_e.y != '0)) != res_taken;
    assign y_abs       = pop_e.y[Y_BITS-1] ? -pop_e.y : pop_e.y;
    assign within_thr  = (32'(y_abs) <= THRESHOLD);
    assign train       = pop && !rst && (mispred || within_thr);

    assign res_mispred = res_mispred_q;
    assign res_err     = res_err_q;

    perceptron_inflight_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .wdata (push_e),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        case (state_q)
            StInit: begin
                row_d = row_q + IDX_BITS'(1);
                if (row_q == IDX_BITS'(ROWS - 1)) begin
                    state_d = StRun;
                end
            end
            StRun:   state_d = StRun;
            default: state_d = StInit;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= StInit;
            row_q         <= '0;
            hist_q        <= '0;
            hist_valid_q  <= '0;
            res_mispred_q <= 1'b0;
            res_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            res_mispred_q <= pop && mispred;
            res_err_q     <= res_valid && (fifo_count == '0) && (state_q == StRun);
            if (pop) begin
                hist_q       <= {hist_q[HIST_LEN-2:0], res_taken};
                hist_valid_q <= {hist_valid_q[HIST_LEN-2:0], 1'b1};
            end
        end
    end

    // Table has no reset of its own; the INIT sweep clears it one row per cycle.
    always_ff @(posedge clk) begin
        if (state_q == StInit) begin
            for (int j = 0; j < NW; j++) begin
                weights_q[row_q][j] <= '0;
            end
        end else if (train) begin
            weights_q[pop_e.idx][0] <=
                WEIGHT_BITS'(sat_add(int'(weights_q[pop_e.idx][0]), res_taken, WMAX));
            for (int j = 0; j < HIST_LEN; j++) begin
                if (pop_e.hist_valid[j]) begin
                    weights_q[pop_e.idx][j+1] <= WEIGHT_BITS'(sat_add(
                        int'(weights_q[pop_e.idx][j+1]), res_taken == pop_e.hist[j], WMAX));
                end
            end
        end
    end

endmodule

// File: tb/tb_perceptron_predictor_gen2.sv
// Directed bench for perceptron_predictor_gen2; a second instance checks weight saturation.
module tb_perceptron_predictor_gen2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               pred_valid = 1'b0;
    logic [15:0]        pred_pc = '0;
    logic               pred_ready, pred_taken;
    logic signed [12:0] pred_y;
    logic               res_valid = 1'b0;
    logic               res_taken = 1'b0;
    logic               res_mispred, res_err;

    logic               s_rst = 1'b1;
    logic               s_pred_valid = 1'b0;
    logic [15:0]        s_pred_pc = '0;
    logic               s_pred_ready, s_pred_taken;
    logic signed [12:0] s_pred_y;
    logic               s_res_valid = 1'b0;
    logic               s_res_taken = 1'b0;
    logic               s_res_mispred, s_res_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    perceptron_predictor_gen2 u_dut (
        .clk         (clk),
        .rst         (rst),
        .pred_valid  (pred_valid),
        .pred_pc     (pred_pc),
        .pred_ready  (pred_ready),
        .pred_taken  (pred_taken),
        .pred_y      (pred_y),
        .res_valid   (res_valid),
        .res_taken   (res_taken),
        .res_mispred (res_mispred),
        .res_err     (res_err)
    );

    perceptron_predictor_gen2 #(.THRESHOLD(2000)) u_sat (
        .clk         (clk),
        .rst         (s_rst),
        .pred_valid  (s_pred_valid),
        .pred_pc     (s_pred_pc),
        .pred_ready  (s_pred_ready),
        .pred_taken  (s_pred_taken),
        .pred_y      (s_pred_y),
        .res_valid   (s_res_valid),
        .res_taken   (s_res_taken),
        .res_mispred (s_res_mispred),
        .res_err     (s_res_err)
    );

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_predict(input logic [15:0] pc, output logic rdy, output logic tk,
                              output logic signed [12:0] y);
        @(negedge clk);
        pred_valid = 1'b1;
        pred_pc    = pc;
        #1;
        rdy = pred_ready;
        tk  = pred_taken;
        y   = pred_y;
        @(posedge clk);
        #1;
        pred_valid = 1'b0;
    endtask

    task automatic peek(input logic [15:0] pc, output logic signed [12:0] y);
        @(negedge clk);
        pred_valid = 1'b0;
        pred_pc    = pc;
        #1;
        y = pred_y;
    endtask

    task automatic do_resolve(input logic t, output logic mp, output logic er);
        @(negedge clk);
        res_valid = 1'b1;
        res_taken = t;
        @(posedge clk);
        #1;
        mp        = res_mispred;
        er        = res_err;
        res_valid = 1'b0;
    endtask

    task automatic test_reset();
        int cnt;
        logic signed [12:0] y;
        do_reset();
        total++;
        if (res_mispred !== 1'b0 || res_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_pulses got %b%b want 00", res_mispred, res_err);
        end
        cnt = 0;
        while (pred_ready !== 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        total++;
        if (cnt != 16) begin
            bad++;
            $display("FAIL reset_sweep_cycles got %0d want 16", cnt);
        end
        for (int r = 0; r < 16; r++) begin
            peek(16'(r), y);
            total++;
            if (y !== 13'sd0) begin
                bad++;
                $display("FAIL reset_row_y row=%0d got %0d want 0", r, y);
            end
        end
    endtask

    // Row 3 always taken: weights settle after 8 trains, y = 8+7+...+0 = 36 > 29.
    task automatic test_train_taken();
        logic rdy, tk, mp, er;
        logic signed [12:0] y;
        int mm, exp_y;
        for (int k = 1; k <= 40; k++) begin
            do_predict(16'h0003, rdy, tk, y);
            mm    = (k - 1 > 8) ? 8 : k - 1;
            exp_y = mm * (mm + 1) / 2;
            total++;
            if (rdy !== 1'b1 || y !== 13'(exp_y) || tk !== (exp_y > 0)) begin
                bad++;
                $display("FAIL train_pred k=%0d got rdy=%b y=%0d tk=%b want rdy=1 y=%0d tk=%b",
                         k, rdy, y, tk, exp_y, exp_y > 0);
            end
            do_resolve(1'b1, mp, er);
            total++;
            if (mp !== (exp_y <= 0) || er !== 1'b0) begin
                bad++;
                $display("FAIL train_res k=%0d got mp=%b er=%b want mp=%b er=0",
                         k, mp, er, exp_y <= 0);
            end
        end
    endtask

    task automatic test_res_err();
        logic mp, er;
        logic signed [12:0] y;
        do_resolve(1'b0, mp, er);
        total++;
        if (er !== 1'b1 || mp !== 1'b0) begin
            bad++;
            $display("FAIL err_pulse got er=%b mp=%b want er=1 mp=0", er, mp);
        end
        @(posedge clk);
        #1;
        total++;
        if (res_err !== 1'b0) begin
            bad++;
            $display("FAIL err_once got %b want 0", res_err);
        end
        peek(16'h0003, y);
        total++;
        if (y !== 13'sd36) begin
            bad++;
            $display("FAIL err_state_unchanged got %0d want 36", y);
        end
    endtask

    task automatic test_fifo_full();
        logic [15:0] pcs [8] = '{16'h3, 16'h5, 16'h3, 16'h7, 16'h3, 16'h9, 16'h3, 16'h0};
        logic        outs [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        logic        exp_mp [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        logic rdy, tk, mp, er;
        logic signed [12:0] y;
        int exp_y;
        for (int i = 0; i < 8; i++) begin
            do_predict(pcs[i], rdy, tk, y);
            exp_y = (pcs[i] == 16'h3) ? 36 : 0;
            total++;
            if (rdy !== 1'b1 || y !== 13'(exp_y)) begin
                bad++;
                $display("FAIL full_push i=%0d got rdy=%b y=%0d want rdy=1 y=%0d",
                         i, rdy, y, exp_y);
            end
        end
        do_predict(16'h3, rdy, tk, y);
        total++;
        if (rdy !== 1'b0) begin
            bad++;
            $display("FAIL full_ready got %b want 0", rdy);
        end
        for (int i = 0; i < 8; i++) begin
            do_resolve(outs[i], mp, er);
            total++;
            if (mp !== exp_mp[i] || er !== 1'b0) begin
                bad++;
                $display("FAIL full_pop i=%0d got mp=%b er=%b want mp=%b er=0",
                         i, mp, er, exp_mp[i]);
            end
        end
        do_resolve(1'b1, mp, er);
        total++;
        if (er !== 1'b1) begin
            bad++;
            $display("FAIL full_dropped got er=%b want 1", er);
        end
    endtask

    task automatic test_rst_mid();
        logic rdy, tk, mp, er;
        logic signed [12:0] y;
        int cnt;
        for (int i = 0; i < 3; i++) begin
            do_predict(16'h3, rdy, tk, y);
        end
        do_reset();
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            do_resolve(1'b1, mp, er);
            cnt++;
            total++;
            if (mp !== 1'b0 || er !== 1'b0 || pred_ready !== 1'b0) begin
                bad++;
                $display("FAIL init_ignore i=%0d got mp=%b er=%b rdy=%b want 0 0 0",
                         i, mp, er, pred_ready);
            end
        end
        while (pred_ready !== 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        total++;
        if (cnt != 16) begin
            bad++;
            $display("FAIL resweep_cycles got %0d want 16", cnt);
        end
        peek(16'h3, y);
        total++;
        if (y !== 13'sd0) begin
            bad++;
            $display("FAIL resweep_row got %0d want 0", y);
        end
        do_resolve(1'b1, mp, er);
        total++;
        if (er !== 1'b1) begin
            bad++;
            $display("FAIL rst_fifo_empty got er=%b want 1", er);
        end
        do_predict(16'h3, rdy, tk, y);
        do_resolve(1'b1, mp, er);
        total++;
        if (mp !== 1'b1) begin
            bad++;
            $display("FAIL rst_first_mp got %b want 1", mp);
        end
        do_predict(16'h3, rdy, tk, y);
        total++;
        if (y !== 13'sd1 || tk !== 1'b1) begin
            bad++;
            $display("FAIL rst_hist_cleared got y=%0d tk=%b want y=1 tk=1", y, tk);
        end
        do_resolve(1'b1, mp, er);
    endtask

    // THRESHOLD=2000 exceeds the 9*127 maximum, so every resolve trains.
    task automatic test_saturate();
        int cnt;
        @(negedge clk);
        s_rst = 1'b1;
        @(posedge clk);
        #1;
        s_rst = 1'b0;
        cnt = 0;
        while (s_pred_ready !== 1'b1 && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        total++;
        if (cnt != 16) begin
            bad++;
            $display("FAIL sat_sweep got %0d want 16", cnt);
        end
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            s_pred_valid = 1'b1;
            s_pred_pc    = 16'h0003;
            #1;
            if (k == 21) begin
                total++;
                if (s_pred_y !== 13'sd144) begin
                    bad++;
                    $display("FAIL sat_mid20 got %0d want 144", s_pred_y);
                end
            end
            if (k == 131) begin
                total++;
                if (s_pred_y !== 13'sd1128) begin
                    bad++;
                    $display("FAIL sat_mid130 got %0d want 1128", s_pred_y);
                end
            end
            @(posedge clk);
            #1;
            s_pred_valid = 1'b0;
            @(negedge clk);
            s_res_valid = 1'b1;
            s_res_taken = 1'b1;
            @(posedge clk);
            #1;
            s_res_valid = 1'b0;
        end
        @(negedge clk);
        #1;
        total++;
        if (s_pred_y !== 13'sd1143 || s_pred_taken !== 1'b1) begin
            bad++;
            $display("FAIL sat_final got y=%0d tk=%b want y=1143 tk=1", s_pred_y, s_pred_taken);
        end
    endtask

    initial begin
        test_reset();
        test_train_taken();
        test_res_err();
        test_fifo_full();
        test_rst_mid();
        test_saturate();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
